// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC constants: default flit width, downstream credit
//                depth, flit-type encodings and injection-FSM state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Default flit width and downstream buffer depth (slots)
    localparam int c_FLIT_W  = 20;
    localparam int c_CREDITS = 4;

    // Flit type lives in the two MSBs of every flit
    localparam logic [1:0] c_FT_HEAD   = 2'b10;
    localparam logic [1:0] c_FT_BODY   = 2'b00;
    localparam logic [1:0] c_FT_TAIL   = 2'b01;
    localparam logic [1:0] c_FT_SINGLE = 2'b11;

    // Injection FSM state encoding
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches requesters
//                starting one past the previous grantee and returns the first
//                active one as a one-hot grant plus its binary index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk the ring from last_grant+1; the first active requester wins
    always_comb begin
        grant   = '0;
        index   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        if (enable) begin
            for (int off = 1; off <= N_REQ; off++) begin
                w_cand = IDX_W'((int'(last_grant) + off) % N_REQ);
                if (!w_found && req[w_cand]) begin
                    grant[w_cand] = 1'b1;
                    index         = w_cand;
                    w_found       = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pe_inject_arbiter
//  Description : Shares one router local input port among N_REQ processing
//                elements. Round-robin between packets, wormhole lock on a
//                head flit until its tail, credit-based flow control toward
//                the router and a one-cycle registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int FLIT_W   = c_FLIT_W,
    parameter int CREDITS  = c_CREDITS,
    localparam int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*FLIT_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      ci,
    output logic [FLIT_W-1:0]         dataout,
    output logic                      out_valid,
    output logic [CNT_W-1:0]          credit_cnt,
    output logic                      err_credit
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // FSM and arbitration history; while LOCKED last_grant is also the owner
    logic [0:0]       r_state_q,      w_state_d;
    logic [IDX_W-1:0] r_last_grant_q, w_last_grant_d;

    // Credit and output stage
    logic [CNT_W-1:0]  r_credit_q,    w_credit_d;
    logic              r_err_q,       w_err_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic [FLIT_W-1:0] r_dataout_q,   w_dataout_d;

    // Selection wires
    logic [N_REQ-1:0]  w_arb_grant;
    logic [IDX_W-1:0]  w_arb_idx;
    logic [N_REQ-1:0]  w_sel_oh;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [FLIT_W-1:0] w_sel_flit;
    logic [1:0]        w_sel_type;
    logic              w_credit_ok;
    logic              w_xfer;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (r_last_grant_q),
        .enable     (r_state_q == c_ST_IDLE),
        .grant      (w_arb_grant),
        .index      (w_arb_idx)
    );

    assign w_credit_ok = (r_credit_q != '0);
    assign w_sel_flit  = req_data[w_sel_idx*FLIT_W +: FLIT_W];
    assign w_sel_type  = w_sel_flit[FLIT_W-1 -: 2];
    assign w_xfer      = |(req_valid & req_ready);

    // FSM state register, restores IDLE with the ring pointer at the last slot
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state_q      <= c_ST_IDLE;
            r_last_grant_q <= IDX_W'(N_REQ - 1);
        end else begin
            r_state_q      <= w_state_d;
            r_last_grant_q <= w_last_grant_d;
        end
    end

    // FSM next state: head locks the grantee, tail releases it
    always_comb begin
        w_state_d      = r_state_q;
        w_last_grant_d = r_last_grant_q;
        if (w_xfer) begin
            case (r_state_q)
                c_ST_IDLE: begin
                    w_last_grant_d = w_sel_idx;
                    if (w_sel_type == c_FT_HEAD) begin
                        w_state_d = c_ST_LOCKED;
                    end
                end
                default: begin
                    // head/single/body while locked are forwarded, no change
                    if (w_sel_type == c_FT_TAIL) begin
                        w_state_d = c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    // FSM outputs: pick the eligible requester and gate ready on credit/reset
    always_comb begin
        w_sel_idx = r_last_grant_q;
        w_sel_oh  = '0;
        if (r_state_q == c_ST_IDLE) begin
            w_sel_idx = w_arb_idx;
            w_sel_oh  = w_arb_grant;
        end else begin
            w_sel_oh[r_last_grant_q] = req_valid[r_last_grant_q];
        end
        req_ready = (RST && w_credit_ok) ? w_sel_oh : '0;
    end

    // Credit accounting, sticky overflow detection and output capture
    always_comb begin
        w_credit_d    = r_credit_q;
        w_err_d       = r_err_q;
        w_out_valid_d = w_xfer;
        w_dataout_d   = w_xfer ? w_sel_flit : r_dataout_q;
        if (w_xfer && !ci) begin
            w_credit_d = r_credit_q - 1'b1;
        end else if (ci && !w_xfer) begin
            if (r_credit_q == CNT_W'(CREDITS)) begin
                w_err_d = 1'b1;
            end else begin
                w_credit_d = r_credit_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_credit_q    <= CNT_W'(CREDITS);
            r_err_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_dataout_q   <= '0;
        end else begin
            r_credit_q    <= w_credit_d;
            r_err_q       <= w_err_d;
            r_out_valid_q <= w_out_valid_d;
            r_dataout_q   <= w_dataout_d;
        end
    end

    assign credit_cnt = r_credit_q;
    assign err_credit = r_err_q;
    assign out_valid  = r_out_valid_q;
    assign dataout    = r_dataout_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_inject_arbiter
//  Description : Directed bench for pe_inject_arbiter. Stimulus pushes the
//                flit it expects to be accepted; a monitor pops and compares
//                whenever out_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_inject_arbiter;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [79:0] req_data;
    logic [3:0]  req_ready;
    logic        ci = 1'b0;
    logic [19:0] dataout;
    logic        out_valid;
    logic [2:0]  credit_cnt;
    logic        err_credit;

    logic [19:0] flit [4];
    logic [19:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    assign req_data = {flit[3], flit[2], flit[1], flit[0]};

    always #5 clk = ~clk;

    pe_inject_arbiter #(
        .N_REQ   (4),
        .FLIT_W  (20),
        .CREDITS (4)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .ci         (ci),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .credit_cnt (credit_cnt),
        .err_credit (err_credit)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive, check ready, record expected flit
    task automatic step(input logic [3:0] v, input logic c, input logic [3:0] exp_rdy,
                        input string name);
        req_valid = v;
        ci        = c;
        #2;
        chk(name, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) sb.push_back(flit[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) flit[i] = 20'h0;

        // Monitor: latency is exactly one cycle, so anything queued must show up
        fork
            forever begin
                logic [19:0] exp_f;
                @(posedge clk);
                #2;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        chk("out_unexpected", 32'(out_valid), 32'd0);
                    end else begin
                        exp_f = sb.pop_front();
                        chk("dataout", 32'(dataout), 32'(exp_f));
                    end
                end else if (sb.size() != 0) begin
                    chk("out_missing", 32'(out_valid), 32'd1);
                    void'(sb.pop_front());
                end
            end
        join_none

        // Reset: ready must stay low even with every requester valid
        @(posedge clk);
        #1;
        step(4'hF, 1'b0, 4'h0, "rst_ready_a");
        step(4'hF, 1'b0, 4'h0, "rst_ready_b");
        RST = 1'b1;
        chk("rst_credit",    32'(credit_cnt), 32'd4);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_dataout",   32'(dataout),    32'd0);
        chk("rst_err",       32'(err_credit), 32'd0);
        step(4'h0, 1'b0, 4'h0, "idle_ready");

        // Round robin over four continuous requesters, ci from cycle 2
        for (int i = 0; i < 4; i++) flit[i] = 20'h30001 + 20'(i);
        step(4'hF, 1'b0, 4'b0001, "rr_g0");
        step(4'hF, 1'b0, 4'b0010, "rr_g1");
        step(4'hF, 1'b1, 4'b0100, "rr_g2");
        step(4'hF, 1'b1, 4'b1000, "rr_g3");
        step(4'hF, 1'b1, 4'b0001, "rr_g0_again");
        step(4'hF, 1'b1, 4'b0010, "rr_g1_again");
        chk("rr_credit", 32'(credit_cnt), 32'd2);
        step(4'h0, 1'b1, 4'h0, "refill_a");
        step(4'h0, 1'b1, 4'h0, "refill_b");
        chk("refill_credit", 32'(credit_cnt), 32'd4);
        chk("refill_err",    32'(err_credit), 32'd0);

        // Wormhole lock: requester 2 waits for requester 1's tail
        flit[0] = 20'hC0005;
        step(4'b0001, 1'b1, 4'b0001, "prime_g0");
        flit[1] = 20'h80011;
        flit[2] = 20'hC0022;
        step(4'b0110, 1'b1, 4'b0010, "pkt_head");
        flit[1] = 20'h00012;
        step(4'b0110, 1'b1, 4'b0010, "pkt_body");
        step(4'b0100, 1'b0, 4'b0000, "pkt_locked_idle");
        flit[1] = 20'h40013;
        step(4'b0110, 1'b1, 4'b0010, "pkt_tail");
        step(4'b0110, 1'b1, 4'b0100, "after_tail_g2");
        chk("pkt_credit", 32'(credit_cnt), 32'd4);

        // Credit exhaustion with five singles from requester 0
        for (int k = 0; k < 4; k++) begin
            flit[0] = 20'hC0031 + 20'(k);
            step(4'b0001, 1'b0, 4'b0001, "single_acc");
        end
        chk("credit_empty", 32'(credit_cnt), 32'd0);
        flit[0] = 20'hC0035;
        step(4'b0001, 1'b0, 4'b0000, "no_credit_ready");
        chk("credit_still_empty", 32'(credit_cnt), 32'd0);
        step(4'b0001, 1'b1, 4'b0000, "ci_at_zero_ready");
        chk("credit_one", 32'(credit_cnt), 32'd1);
        step(4'b0001, 1'b0, 4'b0001, "fifth_acc");
        chk("credit_zero_again", 32'(credit_cnt), 32'd0);
        for (int k = 0; k < 4; k++) step(4'h0, 1'b1, 4'h0, "refill2");
        chk("refill2_credit", 32'(credit_cnt), 32'd4);
        chk("refill2_err",    32'(err_credit), 32'd0);

        // Credit overflow is saturating and sticky
        step(4'h0, 1'b1, 4'h0, "ovf_ready");
        chk("ovf_credit", 32'(credit_cnt), 32'd4);
        chk("ovf_err",    32'(err_credit), 32'd1);
        step(4'h0, 1'b0, 4'h0, "ovf_hold_a");
        step(4'h0, 1'b0, 4'h0, "ovf_hold_b");
        chk("ovf_err_sticky", 32'(err_credit), 32'd1);

        // Lock on requester 3, then reset mid-packet
        flit[3] = 20'h80041;
        step(4'b1001, 1'b1, 4'b1000, "lk_head");
        flit[3] = 20'h00042;
        step(4'b1001, 1'b1, 4'b1000, "lk_body");
        flit[3] = 20'h80043;
        step(4'b1001, 1'b1, 4'b1000, "lk_head_in_locked");
        flit[3] = 20'h00044;
        step(4'b1001, 1'b1, 4'b1000, "lk_still_locked");
        RST = 1'b0;
        step(4'b1001, 1'b1, 4'b0000, "rst_mid_ready");
        RST = 1'b1;
        chk("rst_mid_credit",    32'(credit_cnt), 32'd4);
        chk("rst_mid_out_valid", 32'(out_valid),  32'd0);
        chk("rst_mid_dataout",   32'(dataout),    32'd0);
        chk("rst_mid_err",       32'(err_credit), 32'd0);
        flit[0] = 20'hC0051;
        step(4'b1001, 1'b1, 4'b0001, "post_rst_g0");
        step(4'h0, 1'b0, 4'h0, "drain_a");
        step(4'h0, 1'b0, 4'h0, "drain_b");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
